axi_wr_pkt_writer: RTL and testbench
====================================

AXI_WR_PKT_WRITER -- requirements
Module: axi_wr_pkt_writer

Interface
REQ-001 SHALL have parameter DWIDTH, default 64, packet-memory and WDATA width.
REQ-002 SHALL have parameter AWIDTH, default 6, packet-memory address width (64 entries).
REQ-003 clk  in  1  sole clock, rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 AWID  in  4  write burst ID.
REQ-006 AWLEN  in  4  beats minus one (1..16 beats).
REQ-007 AWVALID  in  1  address valid.
REQ-008 AWREADY  out  1  address accept.
REQ-009 WID  in  4  data beat ID.
REQ-010 WDATA  in  DWIDTH  beat data.
REQ-011 WLAST  in  1  master's last-beat flag.
REQ-012 WVALID  in  1  data valid.
REQ-013 WREADY  out  1  data accept.
REQ-014 BID  out  4  response ID (latched AWID).
REQ-015 BRESP  out  2  2'b00 OKAY, 2'b10 SLVERR.
REQ-016 BVALID  out  1  response valid.
REQ-017 BREADY  in  1  response accept.
REQ-018 f0_waddr  out  AWIDTH  packet-memory write address.
REQ-019 f0_wdata  out  DWIDTH  packet-memory write data.
REQ-020 f0_write  out  1  packet-memory write strobe.
REQ-021 rd_ptr  in  AWIDTH+1  consumer read pointer (MSB = wrap bit).
REQ-022 wr_ptr  out  AWIDTH+1  committed write pointer (MSB = wrap bit).
REQ-023 pkt_done  out  1  one-cycle pulse per committed burst.

Function
REQ-024 FSM states IDLE, DATA, RESP; AWREADY high only in IDLE, WREADY only in DATA, BVALID only in RESP.
REQ-025 free = 64 - ((wr_ptr - rd_ptr) mod 128); IDLE asserts AWREADY only when free >= 16; else AWREADY low, AW held off.
REQ-026 AW handshake latches AWID and AWLEN, clears beat counter, loads local pointer lptr = wr_ptr, enters DATA next cycle.
REQ-027 Each W handshake: next cycle f0_write=1, f0_waddr=lptr[AWIDTH-1:0], f0_wdata=WDATA (one-cycle registered latency); lptr increments, wrapping 63->0 with wrap-bit toggle.
REQ-028 Burst ends on the handshake where beat counter equals latched AWLEN, regardless of WLAST; FSM enters RESP next cycle.
REQ-029 RESP: BVALID held with BID and BRESP stable until BREADY; on BVALID&BREADY FSM returns to IDLE next cycle.
REQ-030 OKAY burst: at RESP entry wr_ptr <= lptr and pkt_done pulses one cycle; rd_ptr changes never alter data already written.
REQ-031 SLVERR burst: wr_ptr unchanged (rollback), no pkt_done, memory beyond wr_ptr is don't-care.
REQ-032 Simultaneous BVALID&BREADY and AWVALID: AW not accepted that cycle (accepted from IDLE).

Reset
REQ-033 rst SHALL force IDLE, AWREADY=WREADY=BVALID=0, BID=0, BRESP=0, f0_write=0, f0_waddr=0, f0_wdata=0, wr_ptr=0, pkt_done=0.
REQ-034 Reset mid-burst SHALL discard the burst with no B response and no further memory writes.

Configuration
REQ-035 With AXI_WR_ERRCHK_EN defined: BRESP=SLVERR if any beat's WID differs from latched AWID, WLAST is 1 before the final beat, or WLAST is 0 on the final beat.
REQ-036 Without AXI_WR_ERRCHK_EN: no checks, BRESP always OKAY, WID/WLAST ignored.

Verification
REQ-037 After reset, AW(ID=3,LEN=3) + 4 beats 0x11..0x44 with WLAST on beat 4 -> writes at addresses 0..3, B(ID=3,OKAY), wr_ptr=4, one pkt_done pulse.
REQ-038 wr_ptr=60, rd_ptr=60, LEN=7 -> writes at addresses 60,61,62,63,0,1,2,3; wr_ptr=0x44 (wrap bit set).
REQ-039 rd_ptr=0, wr_ptr=50 (free 14), AWVALID held -> AWREADY low; raise rd_ptr to 2 -> AWREADY high next cycle.
REQ-040 ERRCHK_EN, LEN=1, WLAST on beat 1 -> BRESP=2'b10, wr_ptr unchanged, no pkt_done; without macro -> OKAY, wr_ptr+2.
REQ-041 rst asserted after beat 2 of LEN=3 -> BVALID never asserts, wr_ptr=0, next burst writes from address 0.

Source files
------------

// File: rtl/axi_wr_pkt_writer.sv
// rtl/axi_wr_pkt_writer.sv - AXI write bursts into a packet-memory ring; AXI_WR_ERRCHK_EN enables WID/WLAST checks
module axi_wr_pkt_writer #(
    parameter int DWIDTH = 64,
    parameter int AWIDTH = 6
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        AWID,
    input  logic [3:0]        AWLEN,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [3:0]        WID,
    input  logic [DWIDTH-1:0] WDATA,
    input  logic              WLAST,
    input  logic              WVALID,
    output logic              WREADY,
    output logic [3:0]        BID,
    output logic [1:0]        BRESP,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [AWIDTH-1:0] f0_waddr,
    output logic [DWIDTH-1:0] f0_wdata,
    output logic              f0_write,
    input  logic [AWIDTH:0]   rd_ptr,
    output logic [AWIDTH:0]   wr_ptr,
    output logic              pkt_done
);

    // A burst is only admitted when a maximum-length (16 beat) burst is guaranteed to fit.
    localparam logic [AWIDTH:0] MAX_USED = (AWIDTH+1)'((1 << AWIDTH) - 16);

    typedef enum logic [1:0] {IDLE, DATA, RESP} state_t;

    state_t          state;
    logic [3:0]      awlen_q;
    logic [3:0]      beat_cnt;
    logic [AWIDTH:0] lptr;
    logic            err_q;
    logic [AWIDTH:0] used;
    logic            space_ok;
    logic            last_beat;
    logic            beat_err;
    logic            burst_err;

    assign used      = wr_ptr - rd_ptr;
    assign space_ok  = (used <= MAX_USED);
    assign last_beat = (beat_cnt == awlen_q);

`ifdef AXI_WR_ERRCHK_EN
    assign beat_err = (WID != BID) || (WLAST != last_beat);
`else
    assign beat_err = 1'b0 & (WLAST | (|WID));
`endif

    assign burst_err = err_q | beat_err;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b0;
            BID      <= 4'd0;
            BRESP    <= 2'b00;
            f0_write <= 1'b0;
            f0_waddr <= '0;
            f0_wdata <= '0;
            wr_ptr   <= '0;
            pkt_done <= 1'b0;
            awlen_q  <= 4'd0;
            beat_cnt <= 4'd0;
            lptr     <= '0;
            err_q    <= 1'b0;
        end else begin
            f0_write <= 1'b0;
            pkt_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (AWREADY && AWVALID) begin
                        AWREADY  <= 1'b0;
                        WREADY   <= 1'b1;
                        BID      <= AWID;
                        awlen_q  <= AWLEN;
                        beat_cnt <= 4'd0;
                        lptr     <= wr_ptr;
                        err_q    <= 1'b0;
                        state    <= DATA;
                    end else begin
                        AWREADY <= space_ok;
                    end
                end
                DATA: begin
                    if (WVALID && WREADY) begin
                        f0_write <= 1'b1;
                        f0_waddr <= lptr[AWIDTH-1:0];
                        f0_wdata <= WDATA;
                        lptr     <= lptr + 1'b1;
                        beat_cnt <= beat_cnt + 1'b1;
                        err_q    <= burst_err;
                        // Beat count alone terminates the burst; WLAST only feeds the error check.
                        if (last_beat) begin
                            WREADY <= 1'b0;
                            BVALID <= 1'b1;
                            BRESP  <= burst_err ? 2'b10 : 2'b00;
                            state  <= RESP;
                            if (!burst_err) begin
                                wr_ptr   <= lptr + 1'b1;
                                pkt_done <= 1'b1;
                            end
                        end
                    end
                end
                RESP: begin
                    if (BREADY) begin
                        BVALID <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_pkt_writer.sv
// tb/tb_axi_wr_pkt_writer.sv - self-checking bench for axi_wr_pkt_writer (directed table, corner sequences, random bursts)
module tb_axi_wr_pkt_writer;

    localparam int DW = 64;
    localparam int AW = 6;
`ifdef AXI_WR_ERRCHK_EN
    localparam bit ERRCHK = 1'b1;
`else
    localparam bit ERRCHK = 1'b0;
`endif
    localparam logic [1:0] ERR = ERRCHK ? 2'b10 : 2'b00;
    localparam int NONE = 99;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [3:0]    AWID = '0;
    logic [3:0]    AWLEN = '0;
    logic          AWVALID = 1'b0;
    logic          AWREADY;
    logic [3:0]    WID = '0;
    logic [DW-1:0] WDATA = '0;
    logic          WLAST = 1'b0;
    logic          WVALID = 1'b0;
    logic          WREADY;
    logic [3:0]    BID;
    logic [1:0]    BRESP;
    logic          BVALID;
    logic          BREADY = 1'b0;
    logic [AW-1:0] f0_waddr;
    logic [DW-1:0] f0_wdata;
    logic          f0_write;
    logic [AW:0]   rd_ptr = '0;
    logic [AW:0]   wr_ptr;
    logic          pkt_done;

    always #5 clk = ~clk;

    axi_wr_pkt_writer #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .AWID(AWID), .AWLEN(AWLEN), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WID(WID), .WDATA(WDATA), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .f0_waddr(f0_waddr), .f0_wdata(f0_wdata), .f0_write(f0_write),
        .rd_ptr(rd_ptr), .wr_ptr(wr_ptr), .pkt_done(pkt_done)
    );

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    typedef struct {
        logic [3:0] id;
        logic [3:0] len;
        int         bad_wid;
        int         wlast_beat;
        logic [1:0] exp_resp;
        logic [AW:0] exp_wr;
    } vec_t;

    wr_t         wq[$];
    int          pd_cnt = 0;
    int          bv_cnt = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [AW:0] exp_wr = '0;
    int          exp_pd = 0;
    vec_t        vt[10];

    always @(negedge clk) begin
        if (f0_write) wq.push_back('{f0_waddr, f0_wdata});
        if (pkt_done) pd_cnt++;
        if (BVALID) bv_cnt++;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset;
        chk("rst_awready", AWREADY, 0);
        chk("rst_wready", WREADY, 0);
        chk("rst_bvalid", BVALID, 0);
        chk("rst_bid", BID, 0);
        chk("rst_bresp", BRESP, 0);
        chk("rst_f0_write", f0_write, 0);
        chk("rst_f0_waddr", f0_waddr, 0);
        chk("rst_f0_wdata", f0_wdata, 0);
        chk("rst_wr_ptr", wr_ptr, 0);
        chk("rst_pkt_done", pkt_done, 0);
    endtask

    task automatic wait_aw;
        int n = 0;
        while (!AWREADY && n < 300) begin tick; n++; end
        chk("aw_ready_wait", AWREADY, 1);
        tick;
        AWVALID = 1'b0;
    endtask

    task automatic send_beat(input logic [3:0] wid, input logic [DW-1:0] data, input logic last);
        int n = 0;
        WVALID = 1'b1; WID = wid; WDATA = data; WLAST = last;
        while (!WREADY && n < 300) begin tick; n++; end
        chk("w_ready_wait", WREADY, 1);
        tick;
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    // Reference: beats land at consecutive ring addresses from the committed pointer;
    // the pointer advances by the beat count only when the burst is OKAY.
    task automatic run_burst(input logic [3:0] id, input logic [3:0] len, input int bad_wid,
                             input int wlast_beat, input bit fixed, input int gaps,
                             input bit hold_aw, output logic [1:0] resp_o);
        logic [DW-1:0] d[16];
        logic [AW:0]   start;
        logic [1:0]    exp_resp;
        logic [AW-1:0] ea;
        bit            err;
        int            n;
        start = exp_wr;
        err = 1'b0;
        wq.delete();
        AWID = id; AWLEN = len; AWVALID = 1'b1;
        wait_aw();
        for (int b = 0; b <= int'(len); b++) begin
            d[b] = fixed ? DW'(17 * (b + 1)) : {$urandom, $urandom};
            repeat ($urandom_range(0, gaps)) tick;
            if (b == bad_wid || ((b == wlast_beat) != (b == int'(len)))) err = 1'b1;
            send_beat((b == bad_wid) ? ~id : id, d[b], b == wlast_beat);
        end
        err = err && ERRCHK;
        exp_resp = err ? 2'b10 : 2'b00;
        if (!err) begin
            exp_wr = start + (AW+1)'(len) + 1'b1;
            exp_pd++;
        end
        n = 0;
        while (!BVALID && n < 300) begin tick; n++; end
        chk("b_valid_wait", BVALID, 1);
        chk("b_id", BID, id);
        chk("b_resp", BRESP, exp_resp);
        chk("wr_ptr", wr_ptr, exp_wr);
        resp_o = BRESP;
        repeat ($urandom_range(0, 3)) begin
            tick;
            chk("b_hold", {BVALID, BID, BRESP}, {1'b1, id, exp_resp});
        end
        if (hold_aw) begin AWVALID = 1'b1; AWID = ~id; end
        BREADY = 1'b1;
        if (hold_aw) chk("aw_during_b", AWREADY, 0);
        tick;
        BREADY = 1'b0;
        chk("b_valid_drop", BVALID, 0);
        if (hold_aw) begin
            chk("aw_after_b", AWREADY, 0);
            AWVALID = 1'b0;
        end
        tick;
        chk("n_writes", wq.size(), int'(len) + 1);
        for (int i = 0; i < wq.size() && i <= int'(len); i++) begin
            ea = start[AW-1:0] + AW'(i);
            chk("wr_addr", wq[i].addr, ea);
            chk("wr_data", wq[i].data, d[i]);
        end
        chk("pkt_done_cnt", pd_cnt, exp_pd);
    endtask

    initial begin
        logic [1:0] r;
        vt[0] = '{4'h3, 4'd3,  NONE, 3,    2'b00, 7'h04};
        vt[1] = '{4'h5, 4'd15, NONE, 15,   2'b00, 7'h14};
        vt[2] = '{4'h6, 4'd15, NONE, 15,   2'b00, 7'h24};
        vt[3] = '{4'h7, 4'd15, NONE, 15,   2'b00, 7'h34};
        vt[4] = '{4'h8, 4'd7,  NONE, 7,    2'b00, 7'h3C};
        vt[5] = '{4'h9, 4'd7,  NONE, 7,    2'b00, 7'h44};
        vt[6] = '{4'hA, 4'd1,  NONE, 0,    ERR,   ERRCHK ? 7'h44 : 7'h46};
        vt[7] = '{4'hB, 4'd0,  0,    0,    ERR,   ERRCHK ? 7'h44 : 7'h47};
        vt[8] = '{4'hC, 4'd2,  NONE, NONE, ERR,   ERRCHK ? 7'h44 : 7'h4A};
        vt[9] = '{4'hD, 4'd0,  NONE, 0,    2'b00, ERRCHK ? 7'h45 : 7'h4B};

        repeat (3) tick;
        chk_reset();
        rst = 1'b0;
        tick;

        for (int i = 0; i < 10; i++) begin
            rd_ptr = exp_wr;
            run_burst(vt[i].id, vt[i].len, vt[i].bad_wid, vt[i].wlast_beat, i == 0, i % 2, 1'b0, r);
            chk("vec_resp", r, vt[i].exp_resp);
            chk("vec_wr_ptr", wr_ptr, vt[i].exp_wr);
        end

        // Space hold-off: 14 free entries blocks AW, 16 free admits it.
        rd_ptr = exp_wr - 7'd50;
        tick;
        AWID = 4'h2; AWLEN = 4'd0; AWVALID = 1'b1;
        repeat (3) begin
            tick;
            chk("aw_held_off", AWREADY, 0);
        end
        rd_ptr = exp_wr - 7'd48;
        tick;
        chk("aw_released", AWREADY, 1);
        run_burst(4'h2, 4'd0, NONE, 0, 1'b0, 0, 1'b1, r);

        repeat (40) begin
            logic [3:0] id;
            logic [3:0] len;
            int bw, wl, sel;
            rd_ptr = exp_wr - (AW+1)'($urandom_range(0, 48));
            id  = 4'($urandom);
            len = 4'($urandom);
            bw  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, int'(len)) : NONE;
            sel = $urandom_range(0, 5);
            wl  = (sel == 0) ? NONE : (sel == 1) ? $urandom_range(0, int'(len)) : int'(len);
            run_burst(id, len, bw, wl, 1'b0, 2, 1'($urandom), r);
        end

        // Reset in the middle of a 4-beat burst.
        rd_ptr = exp_wr;
        AWID = 4'h1; AWLEN = 4'd3; AWVALID = 1'b1;
        wait_aw();
        send_beat(4'h1, 64'hAAAA, 1'b0);
        send_beat(4'h1, 64'hBBBB, 1'b0);
        rst = 1'b1;
        tick;
        chk_reset();
        tick;
        rst = 1'b0;
        rd_ptr = '0;
        wq.delete();
        bv_cnt = 0;
        repeat (20) tick;
        chk("mid_rst_bvalid", bv_cnt, 0);
        chk("mid_rst_writes", wq.size(), 0);
        chk("mid_rst_wr_ptr", wr_ptr, 0);
        exp_wr = '0;
        run_burst(4'h4, 4'd3, NONE, 3, 1'b1, 1, 1'b0, r);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
